// File: rtl/spi_xfer_sched.sv
// SPI transfer sequencer, fixed mode 0 (CPOL=0, CPHA=0), MSB first.
// Takes one request at a time, drives the external SCLK generator's
// go/enable/last_clk/divider inputs, shifts MOSI on the generator's falling-edge
// pulses, samples MISO on its rising-edge pulses and returns the received word.
module spi_xfer_sched #(
  parameter int MAX_LEN   = 32,
  parameter int LEN_W     = 5,
  parameter int DIV_LEN   = 16,
  parameter int SS_NUM    = 8,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [MAX_LEN-1:0] req_data,
  input  logic [LEN_W-1:0]   req_len,
  input  logic [DIV_LEN-1:0] req_div,
  input  logic [SS_NUM-1:0]  req_ss,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic [SS_NUM-1:0]  ss_pad_o,
  output logic               mosi,
  input  logic               miso,
  output logic               clgen_go,
  output logic               clgen_enable,
  output logic               clgen_last_clk,
  output logic [DIV_LEN-1:0] clgen_divider,
  input  logic               clgen_pos_edge,
  input  logic               clgen_neg_edge
);

  // A zero cycle count would skip the phase entirely; at least one cycle is kept.
  localparam int SETUP_N = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
  localparam int HOLD_N  = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
  localparam int CNT_W   = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [MAX_LEN-1:0]   data_lat;
  logic [DIV_LEN-1:0]   div_lat;
  logic [SS_NUM-1:0]    ss_lat;
  logic [LEN_W:0]       rem;
  logic [MAX_LEN-1:0]   rx_shreg;
  logic [CNT_W-1:0]     phase_cnt;
  logic                 go_first;
  logic                 mosi_r;

  logic [LEN_W:0]       len_eff;
  logic [LEN_W-1:0]     tx_idx;
  logic [LEN_W-1:0]     rem_idx;
  logic                 accept;

  // Request length decode: 0 means a full MAX_LEN-bit word. The LEN_W-bit
  // subtractions wrap 0 -> MAX_LEN-1, which is exactly the MSB index needed.
  always_comb begin
    len_eff = (req_len == '0) ? (LEN_W+1)'(MAX_LEN) : {1'b0, req_len};
    tx_idx  = req_len - 1'b1;
    rem_idx = rem[LEN_W-1:0] - 1'b1;
    accept  = (state == S_IDLE) && req_valid;
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    busy           = 1'b1;
    rsp_valid      = 1'b0;
    ss_pad_o       = '1;
    clgen_enable   = 1'b0;
    clgen_go       = 1'b0;
    clgen_last_clk = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nxt = S_SETUP;
      end
      S_SETUP: begin
        ss_pad_o = ~ss_lat;
        if (phase_cnt == '0) state_nxt = S_XFER;
      end
      S_XFER: begin
        ss_pad_o       = ~ss_lat;
        clgen_enable   = 1'b1;
        clgen_go       = go_first;
        clgen_last_clk = (rem == '0);
        if (clgen_neg_edge && (rem == '0)) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        ss_pad_o = ~ss_lat;
        if (phase_cnt == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Transfer payload and slave mask, captured on accept; only read while busy
  always_ff @(posedge clk_in) begin
    if (accept) begin
      data_lat <= req_data;
      ss_lat   <= req_ss;
    end
  end

  // Bit counter, phase timer, go pulse, MOSI shifting and MISO capture
  always_ff @(posedge clk_in) begin
    if (rst) begin
      rem       <= '0;
      phase_cnt <= '0;
      go_first  <= 1'b0;
      mosi_r    <= 1'b0;
      rx_shreg  <= '0;
      div_lat   <= '1;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            rem       <= len_eff;
            phase_cnt <= CNT_W'(SETUP_N - 1);
            rx_shreg  <= '0;
            mosi_r    <= req_data[tx_idx];
            div_lat   <= req_div;
          end
        end
        S_SETUP: begin
          if (phase_cnt != '0) phase_cnt <= phase_cnt - 1'b1;
          else                 go_first  <= 1'b1;
        end
        S_XFER: begin
          go_first <= 1'b0;
          if (clgen_pos_edge && (rem != '0)) begin
            rx_shreg <= {rx_shreg[MAX_LEN-2:0], miso};
            rem      <= rem - 1'b1;
          end
          if (clgen_neg_edge) begin
            if (rem != '0) begin
              mosi_r <= data_lat[rem_idx];
            end else begin
              mosi_r    <= 1'b0;
              phase_cnt <= CNT_W'(HOLD_N - 1);
            end
          end
        end
        S_HOLD: begin
          if (phase_cnt != '0) phase_cnt <= phase_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_data      = rx_shreg;
  assign mosi          = mosi_r;
  assign clgen_divider = div_lat;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Bench for spi_xfer_sched: a behavioural SCLK generator answers the go/enable/
// last_clk handshake, a monitor counts consumed edge pulses, and a scoreboard
// queue holds the expected received word of every accepted request.
module tb_spi_xfer_sched;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic [4:0]  req_len;
  logic [15:0] req_div;
  logic [7:0]  req_ss;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;
  logic [7:0]  ss_pad_o;
  logic        mosi;
  logic        miso;
  logic        clgen_go;
  logic        clgen_enable;
  logic        clgen_last_clk;
  logic [15:0] clgen_divider;
  logic        clgen_pos_edge = 1'b0;
  logic        clgen_neg_edge = 1'b0;

  logic        tie1 = 1'b0;
  assign miso = tie1 ? 1'b1 : mosi;

  always #5 clk_in = ~clk_in;

  spi_xfer_sched dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_data       (req_data),
    .req_len        (req_len),
    .req_div        (req_div),
    .req_ss         (req_ss),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .busy           (busy),
    .ss_pad_o       (ss_pad_o),
    .mosi           (mosi),
    .miso           (miso),
    .clgen_go       (clgen_go),
    .clgen_enable   (clgen_enable),
    .clgen_last_clk (clgen_last_clk),
    .clgen_divider  (clgen_divider),
    .clgen_pos_edge (clgen_pos_edge),
    .clgen_neg_edge (clgen_neg_edge)
  );

  // Behavioural SCLK generator: SCLK idles low, toggles every divider+1 clocks,
  // and refuses to start a new rising edge once last_clk is asserted.
  logic        gen_run  = 1'b0;
  logic        gen_sclk = 1'b0;
  logic [15:0] gen_cnt  = '0;
  always @(posedge clk_in) begin
    clgen_pos_edge <= 1'b0;
    clgen_neg_edge <= 1'b0;
    if (rst || !clgen_enable) begin
      gen_run  <= 1'b0;
      gen_sclk <= 1'b0;
    end else if (clgen_go && !gen_run) begin
      gen_run  <= 1'b1;
      gen_sclk <= 1'b0;
      gen_cnt  <= clgen_divider;
    end else if (gen_run) begin
      if (gen_cnt == 16'd0) begin
        gen_cnt <= clgen_divider;
        if (!gen_sclk) begin
          if (clgen_last_clk) begin
            gen_run <= 1'b0;
          end else begin
            gen_sclk       <= 1'b1;
            clgen_pos_edge <= 1'b1;
          end
        end else begin
          gen_sclk       <= 1'b0;
          clgen_neg_edge <= 1'b1;
        end
      end else begin
        gen_cnt <= gen_cnt - 16'd1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_q[$];
  logic [7:0]  exp_ss = 8'hFF;

  // Per-transfer monitor, cleared whenever busy rises
  int   pos_cnt = 0;
  int   neg_cnt = 0;
  int   go_cnt  = 0;
  int   lc_at   = 0;
  logic lc_seen = 1'b0;
  logic ss_bad  = 1'b0;
  logic busy_d  = 1'b0;
  initial begin
    forever begin
      @(negedge clk_in);
      if (busy && !busy_d) begin
        pos_cnt = 0;
        neg_cnt = 0;
        go_cnt  = 0;
        lc_at   = 0;
        lc_seen = 1'b0;
        ss_bad  = 1'b0;
      end
      busy_d = busy;
      if (clgen_enable) begin
        if (clgen_last_clk && !lc_seen) begin
          lc_seen = 1'b1;
          lc_at   = pos_cnt;
        end
        if (clgen_pos_edge) pos_cnt++;
        if (clgen_neg_edge) neg_cnt++;
        if (clgen_go) go_cnt++;
        if (ss_pad_o !== exp_ss) ss_bad = 1'b1;
      end
    end
  end

  task automatic send_req(input logic [31:0] d, input logic [4:0] l,
                          input logic [15:0] dv, input logic [7:0] s);
    int          n;
    int          k;
    logic [31:0] m;
    n = (l == 5'd0) ? 32 : int'(l);
    m = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    exp_ss    = ~s;
    req_data  = d;
    req_len   = l;
    req_div   = dv;
    req_ss    = s;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 200) begin
      @(negedge clk_in);
      k++;
    end
    if (!req_ready) begin
      check_val("req_accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(tie1 ? m : (d & m));
    @(negedge clk_in);
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!rsp_valid && k < 3000) begin
      @(negedge clk_in);
      k++;
    end
    if (!rsp_valid) check_val({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input string tag);
    wait_valid(tag);
    if (!rsp_valid) return;
    if (exp_q.size() == 0) check_val({tag, "_unexpected"}, 32'd1, 32'd0);
    else                   check_val(tag, rsp_data, exp_q.pop_front());
    check_val({tag, "_ss_released"}, {24'd0, ss_pad_o}, 32'hFF);
    rsp_ready = 1'b1;
    @(negedge clk_in);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    int          k;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_data  = '0;
    req_len   = '0;
    req_div   = '0;
    req_ss    = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk_in);
    rst = 1'b0;

    // reset state
    check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rst_rsp_data", rsp_data, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_ss", {24'd0, ss_pad_o}, 32'hFF);
    check_val("rst_mosi", {31'd0, mosi}, 32'd0);
    check_val("rst_go", {31'd0, clgen_go}, 32'd0);
    check_val("rst_enable", {31'd0, clgen_enable}, 32'd0);
    check_val("rst_last_clk", {31'd0, clgen_last_clk}, 32'd0);
    check_val("rst_divider", {16'd0, clgen_divider}, 32'hFFFF);

    // 8-bit loopback
    send_req(32'h0000_00A5, 5'd8, 16'd1, 8'h01);
    wait_rsp("t1_rsp");
    check_val("t1_pos_cnt", pos_cnt, 32'd8);
    check_val("t1_neg_cnt", neg_cnt, 32'd8);
    check_val("t1_go_cnt", go_cnt, 32'd1);
    check_val("t1_ss_asserted", {31'd0, ss_bad}, 32'd0);

    // full 32-bit word via len=0
    send_req(32'hDEAD_BEEF, 5'd0, 16'd2, 8'h10);
    wait_rsp("t2_rsp");
    check_val("t2_pos_cnt", pos_cnt, 32'd32);
    check_val("t2_neg_cnt", neg_cnt, 32'd32);
    check_val("t2_last_clk_at", lc_at, 32'd32);

    // fastest divider, MISO tied high
    tie1 = 1'b1;
    send_req(32'h0000_0009, 5'd4, 16'd0, 8'h02);
    wait_rsp("t3_rsp");
    check_val("t3_go_cnt", go_cnt, 32'd1);
    check_val("t3_pos_cnt", pos_cnt, 32'd4);
    tie1 = 1'b0;

    // response backpressure with a competing request
    send_req(32'h0000_003C, 5'd8, 16'd1, 8'h04);
    wait_valid("t4_valid");
    held      = (exp_q.size() != 0) ? exp_q[0] : 32'd0;
    req_data  = 32'h1234_5678;
    req_len   = 5'd16;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      check_val("t4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_val("t4_rsp_data", rsp_data, held);
      check_val("t4_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    wait_rsp("t4_rsp");
    @(negedge clk_in);
    check_val("t4_no_accept", {31'd0, busy}, 32'd0);

    // reset in the middle of a transfer
    send_req(32'h0000_00C3, 5'd8, 16'd3, 8'h08);
    @(negedge clk_in);
    k = 0;
    while (pos_cnt < 3 && k < 500) begin
      @(negedge clk_in);
      k++;
    end
    check_val("t5_reached_bit3", {31'd0, pos_cnt >= 3}, 32'd1);
    rst = 1'b1;
    @(negedge clk_in);
    check_val("t5_busy", {31'd0, busy}, 32'd0);
    check_val("t5_ss", {24'd0, ss_pad_o}, 32'hFF);
    check_val("t5_enable", {31'd0, clgen_enable}, 32'd0);
    check_val("t5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("t5_mosi", {31'd0, mosi}, 32'd0);
    rst = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    repeat (20) @(negedge clk_in);
    check_val("t5_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // back-to-back requests to different slaves
    send_req(32'h0000_005A, 5'd8, 16'd0, 8'h01);
    wait_rsp("t6a_rsp");
    check_val("t6a_ss_asserted", {31'd0, ss_bad}, 32'd0);
    send_req(32'h0000_81C3, 5'd16, 16'd0, 8'h80);
    wait_rsp("t6b_rsp");
    check_val("t6b_ss_asserted", {31'd0, ss_bad}, 32'd0);
    check_val("t6b_pos_cnt", pos_cnt, 32'd16);
    check_val("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
